// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: buffers one WIDTH-bit word and shifts it out MSB-first, one bit per clock.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_feeder #(
   parameter int unsigned WIDTH      = 8,
   parameter logic        IDLE_LEVEL = 1'b1,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             x_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [3:0]       GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(int'(GAP_CYCLES) - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef SERIAL_FEEDER_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_GAP    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hold_reg_q, hold_reg_d;
   logic               hold_full_q, hold_full_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         gap_q, gap_d;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic accept;
   logic load;
   logic end_frame;

   always_comb begin
      state_d     = state_q;
      hold_reg_d  = hold_reg_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d    = parity_q;
`endif
      load        = 1'b0;
      end_frame   = 1'b0;
      accept      = data_valid && !hold_full_q;

      // Acceptance only happens while empty, so it never collides with a reload.
      if (accept) begin
         hold_reg_d  = data_in;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (hold_full_q) load = 1'b1;
         end
         ST_SHIFT: begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FEEDER_PARITY_EN
               state_d = ST_PARITY;
`else
               end_frame = 1'b1;
`endif
            end
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         ST_PARITY: begin
            end_frame = 1'b1;
         end
`endif
         ST_GAP: begin
            gap_d = gap_q + 4'd1;
            if (gap_q == GAP_LAST) begin
               if (hold_full_q) load = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (end_frame) begin
         if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = 4'd0;
         end else if (hold_full_q) begin
            load = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end

      if (load) begin
         shift_d     = hold_reg_q;
         cnt_d       = '0;
         hold_full_d = 1'b0;
         state_d     = ST_SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_d    = ^hold_reg_q;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         hold_reg_q  <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hold_reg_q  <= hold_reg_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Outputs decode registered state only; data_ready is the sole path from a flag.
   always_comb begin
      x_out      = IDLE_LEVEL;
      bit_valid  = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         ST_SHIFT: begin
            x_out     = shift_q[WIDTH-1];
            bit_valid = 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
            frame_done = (cnt_q == LAST_BIT);
`endif
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         ST_PARITY: begin
            x_out      = parity_q;
            bit_valid  = 1'b1;
            frame_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign data_ready = !hold_full_q;
   assign busy       = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: instance 0 runs with no gap, instance 1 with a 3-cycle gap.
module tb_serial_word_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      logic b;
      logic fd;
      int   pre;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [7:0] din [2];
   logic [1:0] dv, rdy, xo, bv, bz, fd;

   exp_t exp_q [2][$];
   int   idle_run [2];
   int   n_checks;
   int   n_fail;

   serial_word_feeder #(.WIDTH(8), .IDLE_LEVEL(1'b1), .GAP_CYCLES(0)) u_dut0 (
      .clock(clock), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
      .data_ready(rdy[0]), .x_out(xo[0]), .bit_valid(bv[0]), .busy(bz[0]),
      .frame_done(fd[0])
   );

   serial_word_feeder #(.WIDTH(8), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) u_dut1 (
      .clock(clock), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
      .data_ready(rdy[1]), .x_out(xo[1]), .bit_valid(bv[1]), .busy(bz[1]),
      .frame_done(fd[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic push_word(input int i, input logic [7:0] w, input int pre);
      exp_t e;
      for (int k = 7; k >= 0; k--) begin
         e.b   = w[k];
         e.fd  = (k == 0) && !PAR;
         e.pre = (k == 7) ? pre : 0;
         exp_q[i].push_back(e);
      end
      if (PAR) begin
         e.b   = ^w;
         e.fd  = 1'b1;
         e.pre = 0;
         exp_q[i].push_back(e);
      end
   endtask

   // Leaves data_valid high so consecutive calls model a source holding valid continuously.
   task automatic send_word(input int i, input logic [7:0] w, input int pre);
      int n;
      din[i] = w;
      dv[i]  = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!rdy[i] && n < 200);
      if (!rdy[i]) begin
         check_val($sformatf("send_timeout%0d", i), rdy[i], 1);
      end else begin
         push_word(i, w, pre);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drain(input int i);
      int n;
      n = 0;
      while ((exp_q[i].size() != 0 || bz[i]) && n < 300) begin
         @(negedge clock);
         n++;
      end
      check_val($sformatf("drain_q%0d", i), exp_q[i].size(), 0);
      check_val($sformatf("drain_busy%0d", i), bz[i], 0);
      check_val($sformatf("drain_x%0d", i), xo[i], 1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      exp_t e;
      idle_run[0] = 0;
      idle_run[1] = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            for (int i = 0; i < 2; i++) begin
               if (bv[i]) begin
                  if (exp_q[i].size() == 0) begin
                     check_val($sformatf("unexp_bit%0d", i), bv[i], 0);
                  end else begin
                     e = exp_q[i].pop_front();
                     check_val($sformatf("bit%0d", i), xo[i], e.b);
                     check_val($sformatf("frame_done%0d", i), fd[i], e.fd);
                     if (e.pre >= 0) check_val($sformatf("idle_before%0d", i), idle_run[i], e.pre);
                  end
                  idle_run[i] = 0;
               end else begin
                  check_val($sformatf("idle_x%0d", i), xo[i], 1);
                  check_val($sformatf("idle_fd%0d", i), fd[i], 0);
                  idle_run[i]++;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      dv       = 2'b00;
      din[0]   = 8'h00;
      din[1]   = 8'h00;

      repeat (3) @(posedge clock);
      #3 reset = 1'b1;

      // Quiet line after reset release.
      repeat (20) begin
         @(negedge clock);
         check_val("rst_x", xo[0], 1);
         check_val("rst_bv", bv[0], 0);
         check_val("rst_busy", bz[0], 0);
         check_val("rst_ready", rdy[0], 1);
      end
      @(posedge clock);
      #1;

      // Single word; data_in changes after capture must not matter.
      send_word(0, 8'b1001_1101, -1);
      dv[0]  = 1'b0;
      din[0] = 8'h00;
      @(negedge clock);
      check_val("lat_bv", bv[0], 0);
      check_val("lat_busy", bz[0], 1);
      drain(0);

      // Back-to-back words with valid held high.
      send_word(0, 8'hF0, -1);
      send_word(0, 8'h0F, 0);
      dv[0] = 1'b0;
      repeat (7) begin
         @(negedge clock);
         check_val("b2b_ready_low", rdy[0], 0);
      end
      @(negedge clock);
      check_val("b2b_ready_reload", rdy[0], 1);
      drain(0);

      // Gap instance: two queued words separated by exactly three idle cycles.
      send_word(1, 8'hC3, -1);
      send_word(1, 8'h5A, 3);
      dv[1] = 1'b0;
      drain(1);

      // Random streams on both instances.
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 6; j++) begin
            send_word(i, 8'($urandom), (j == 0) ? -1 : ((i == 0) ? 0 : 3));
         end
         dv[i] = 1'b0;
         drain(i);
      end

      // Asynchronous reset on the 4th bit of 8'hA5 with a second word queued.
      send_word(0, 8'hA5, -1);
      send_word(0, 8'h3C, -1);
      dv[0] = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      check_val("pre_rst_bv", bv[0], 1);
      check_val("pre_rst_busy", bz[0], 1);
      #1 reset = 1'b0;
      #1;
      check_val("mid_rst_x", xo[0], 1);
      check_val("mid_rst_bv", bv[0], 0);
      check_val("mid_rst_busy", bz[0], 0);
      check_val("mid_rst_fd", fd[0], 0);
      check_val("mid_rst_ready", rdy[0], 1);
      exp_q[0].delete();
      exp_q[1].delete();
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      repeat (20) begin
         @(negedge clock);
         check_val("post_rst_ready", rdy[0], 1);
         check_val("post_rst_bv", bv[0], 0);
         check_val("post_rst_busy", bz[0], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
